imem_loader: RTL and testbench

//   Writer side of the instruction memory: receives a program as a byte stream (valid/ready),

---
 rtl/imem_loader_pkg.sv | 24 ++
 rtl/imem_loader_timeout.sv | 29 ++
 rtl/imem_loader.sv | 155 +++++++++++++++
 tb/tb_imem_loader.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding and stream framing.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLen0,
    StLen1,
    StData,
    StWrite,
    StDone,
    StErr
  } state_e;

  // The first length byte on the stream is the low byte of the word count.
  localparam bit LenLoFirst = 1'b1;

  localparam int unsigned NumLanes = 4;
  localparam int unsigned LaneW    = $clog2(NumLanes);

  function automatic logic is_loading(state_e s);
    return (s == StLen0) || (s == StLen1) || (s == StData);
  endfunction

endpackage

// File: rtl/imem_loader_timeout.sv
// Idle-cycle watchdog for the loader: counts cycles without a byte transfer and saturates.
module loader_timeout #(
  parameter int unsigned Limit = 65535
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CntW = (Limit > 0) ? $clog2(Limit + 1) : 1;
  localparam logic [CntW-1:0] LimitC = CntW'(Limit);

  logic [CntW-1:0] count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (enable_i && (count_q != LimitC)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expired_o = (count_q == LimitC);

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader: frames a length-prefixed image into 32-bit words, writes them
// to the instruction memory and holds the core in reset until a clean image is in place.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int unsigned TIMEOUT    = 65535
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [31:0]           imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam logic [31:0] MaxWords = 32'd1 << ADDR_WIDTH;

  state_e              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [15:0]         len_full;
  logic [LaneW-1:0]    lane_q, lane_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         addr_q, addr_d;
  logic [ADDR_WIDTH:0] words_q, words_d;

  logic rx_ready_q, imem_we_q, core_hold_q, busy_q, done_q, error_q;
  logic transfer, start_ok, tmo_expired;

  assign transfer = rx_valid & rx_ready_q;
  assign start_ok = start & ((state_q == StIdle) | (state_q == StDone) | (state_q == StErr));
  assign len_full = LenLoFirst ? {rx_data, len_q[7:0]} : {len_q[15:8], rx_data};

  loader_timeout #(
    .Limit (TIMEOUT)
  ) u_timeout (
    .clk_i     (CLK),
    .rst_ni    (RESET),
    .clear_i   (transfer | start_ok),
    .enable_i  (is_loading(state_q) & ~transfer),
    .expired_o (tmo_expired)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    lane_d  = lane_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    words_d = words_q;

    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d = StLen0;
          words_d = '0;
          addr_d  = BASE_ADDR;
          lane_d  = '0;
        end
      end
      StLen0: begin
        if (tmo_expired) begin
          state_d = StErr;
        end else if (transfer) begin
          if (LenLoFirst) len_d[7:0]  = rx_data;
          else            len_d[15:8] = rx_data;
          state_d = StLen1;
        end
      end
      StLen1: begin
        if (tmo_expired) begin
          state_d = StErr;
        end else if (transfer) begin
          len_d  = len_full;
          lane_d = '0;
          if (len_full == 16'd0) begin
            state_d = StDone;
          end else if (32'(len_full) > MaxWords) begin
            // Oversized image is rejected before anything touches the memory.
            state_d = StErr;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (tmo_expired) begin
          state_d = StErr;
        end else if (transfer) begin
          wdata_d[8*lane_q +: 8] = rx_data;
          lane_d = lane_q + 1'b1;
          if (lane_q == LaneW'(NumLanes - 1)) state_d = StWrite;
        end
      end
      StWrite: begin
        words_d = words_q + 1'b1;
        addr_d  = addr_q + 32'd4;
        if ((32'(words_q) + 32'd1) == 32'(len_q)) state_d = StDone;
        else                                       state_d = StData;
      end
      default: state_d = StIdle;
    endcase
  end

  // Status outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= StIdle;
      len_q       <= '0;
      lane_q      <= '0;
      wdata_q     <= '0;
      addr_q      <= BASE_ADDR;
      words_q     <= '0;
      rx_ready_q  <= 1'b0;
      imem_we_q   <= 1'b0;
      core_hold_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      lane_q      <= lane_d;
      wdata_q     <= wdata_d;
      addr_q      <= addr_d;
      words_q     <= words_d;
      rx_ready_q  <= is_loading(state_d);
      imem_we_q   <= (state_d == StWrite);
      core_hold_q <= (state_d != StDone);
      busy_q      <= is_loading(state_d) | (state_d == StWrite);
      done_q      <= (state_d == StDone);
      error_q     <= (state_d == StErr);
    end
  end

  assign rx_ready     = rx_ready_q;
  assign imem_we      = imem_we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign core_hold    = core_hold_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed + randomized bench for imem_loader with a word-level reference of the byte stream.
module tb_imem_loader;

  localparam int unsigned AW   = 8;
  localparam logic [31:0] BASE = 32'h0;
  localparam int unsigned TMO  = 16;

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready, imem_we, core_hold, busy, done, error;
  logic [31:0]   imem_addr, imem_wdata;
  logic [AW:0]   words_loaded;

  int tests = 0;
  int fails = 0;

  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];

  imem_loader #(
    .ADDR_WIDTH (AW),
    .BASE_ADDR  (BASE),
    .TIMEOUT    (TMO)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .start        (start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .core_hold    (core_hold),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 CLK = ~CLK;

  // Memory-side observer: every write strobe seen at a clock edge.
  always @(posedge CLK) begin
    if (RESET && imem_we) begin
      got_addr.push_back(imem_addr);
      got_data.push_back(imem_wdata);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $error("FAIL %s: observed 'h%0h required 'h%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic push(input logic [7:0] b);
    int n;
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (rx_ready !== 1'b1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 50) check("rx_ready_wait", rx_ready, 1'b1);
    @(negedge CLK);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (done !== 1'b1 && error !== 1'b1 && n < 40) begin
      @(negedge CLK);
      n++;
    end
  endtask

  task automatic run_load(input int n, input int gmin, input int gmax, input bit poke,
                          input string tag);
    logic [7:0]  bytes[$];
    logic [31:0] w;
    logic [AW:0] exp_w;
    bit          ok;
    int          nwr;
    ok = (n <= (1 << AW));
    got_addr.delete();
    got_data.delete();
    pulse_start();
    push(n[7:0]);
    push(n[15:8]);
    if (ok) begin
      for (int i = 0; i < 4 * n; i++) bytes.push_back(8'($urandom));
      for (int i = 0; i < 4 * n; i++) begin
        push(bytes[i]);
        if (gmax > 0) begin
          rx_valid = 1'b0;
          repeat ($urandom_range(gmax, gmin)) @(negedge CLK);
        end
        if (poke && i == 1) begin
          rx_valid = 1'b0;
          pulse_start();
        end
      end
    end
    rx_valid = 1'b0;
    wait_end();
    exp_w = ok ? n[AW:0] : '0;
    nwr   = ok ? n : 0;
    check({tag, ".done"}, done, ok);
    check({tag, ".error"}, error, !ok);
    check({tag, ".core_hold"}, core_hold, !ok);
    check({tag, ".busy"}, busy, 1'b0);
    check({tag, ".words_loaded"}, words_loaded, exp_w);
    check({tag, ".num_writes"}, got_addr.size(), nwr);
    for (int i = 0; i < nwr && i < got_addr.size(); i++) begin
      w = 32'(bytes[4*i]) | (32'(bytes[4*i+1]) << 8) | (32'(bytes[4*i+2]) << 16) |
          (32'(bytes[4*i+3]) << 24);
      check({tag, ".addr"}, got_addr[i], BASE + 32'(4 * i));
      check({tag, ".data"}, got_data[i], w);
    end
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge CLK);
    check("rst.rx_ready", rx_ready, 1'b0);
    check("rst.imem_we", imem_we, 1'b0);
    check("rst.imem_addr", imem_addr, BASE);
    check("rst.imem_wdata", imem_wdata, 32'h0);
    check("rst.core_hold", core_hold, 1'b1);
    check("rst.busy", busy, 1'b0);
    check("rst.done", done, 1'b0);
    check("rst.error", error, 1'b0);
    check("rst.words", words_loaded, 9'd0);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    check("idle.core_hold", core_hold, 1'b1);
    check("idle.rx_ready", rx_ready, 1'b0);

    // Directed two-word image; second word's first byte waits out the WRITE cycle
    got_addr.delete();
    got_data.delete();
    pulse_start();
    check("n2.busy", busy, 1'b1);
    push(8'h02); push(8'h00);
    push(8'h13); push(8'h05); push(8'h10); push(8'h00);
    check("n2.we_latency", imem_we, 1'b1);
    check("n2.we_rx_ready", rx_ready, 1'b0);
    check("n2.we_addr", imem_addr, 32'h0);
    check("n2.we_data", imem_wdata, 32'h00100513);
    push(8'hB3); push(8'h05); push(8'hA5); push(8'h00);
    rx_valid = 1'b0;
    wait_end();
    check("n2.done", done, 1'b1);
    check("n2.core_hold", core_hold, 1'b0);
    check("n2.words", words_loaded, 9'd2);
    check("n2.num_writes", got_addr.size(), 2);
    if (got_addr.size() == 2) begin
      check("n2.addr0", got_addr[0], 32'h0);
      check("n2.data0", got_data[0], 32'h00100513);
      check("n2.addr1", got_addr[1], 32'h4);
      check("n2.data1", got_data[1], 32'h00A505B3);
    end

    // Empty image
    run_load(0, 0, 0, 1'b0, "n0");

    // Restart from DONE re-holds the core on the next cycle
    pulse_start();
    check("redone.core_hold", core_hold, 1'b1);
    check("redone.busy", busy, 1'b1);
    check("redone.done", done, 1'b0);
    push(8'h00); push(8'h00);
    rx_valid = 1'b0;
    check("redone.done2", done, 1'b1);

    // One word over capacity
    run_load(257, 0, 0, 1'b0, "n257");

    // Idle gap past the timeout after the 2nd data byte
    got_addr.delete();
    got_data.delete();
    pulse_start();
    push(8'h03); push(8'h00); push(8'h11); push(8'h22);
    rx_valid = 1'b0;
    repeat (TMO + 2) @(negedge CLK);
    check("tmo.error", error, 1'b1);
    check("tmo.busy", busy, 1'b0);
    check("tmo.core_hold", core_hold, 1'b1);
    check("tmo.rx_ready", rx_ready, 1'b0);
    check("tmo.num_writes", got_addr.size(), 0);
    run_load(3, 0, 2, 1'b0, "restart");

    // Gaps just under the timeout are tolerated
    run_load(1, TMO - 2, TMO - 2, 1'b0, "slowgap");

    // Randomized images with random idle gaps
    for (int k = 0; k < 6; k++) run_load($urandom_range(8, 1), 0, 3, 1'b0, "rand");

    // start while busy is ignored
    run_load(3, 0, 1, 1'b1, "busy_start");

    // Full capacity
    run_load(1 << AW, 0, 0, 1'b0, "full");

    // Reset asserted mid-DATA
    pulse_start();
    push(8'h04); push(8'h00);
    for (int i = 0; i < 5; i++) push(8'(i + 8'h40));
    RESET = 1'b0;
    #1;
    check("mid.rx_ready", rx_ready, 1'b0);
    check("mid.imem_we", imem_we, 1'b0);
    check("mid.imem_addr", imem_addr, BASE);
    check("mid.imem_wdata", imem_wdata, 32'h0);
    check("mid.core_hold", core_hold, 1'b1);
    check("mid.busy", busy, 1'b0);
    check("mid.done", done, 1'b0);
    check("mid.error", error, 1'b0);
    check("mid.words", words_loaded, 9'd0);
    rx_valid = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    run_load(2, 0, 1, 1'b0, "after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
